memory_mutator_ida: RTL and testbench

//   Store-path (outgoing) memory formatter for the ERV24 core; counterpart of the load-path return formatter.
//   - Accepts a store request: byte address, 32-bit data, access size.
//   - Computes byte enables and lane-shifted write data.
//   - Runs the write on the data-memory bus with a valid/ack handshake.
//   - Reports completion, misalignment or illegal size to the pipeline.

---
 rtl/memory_mutator_ida.sv | 149 ++++++++++++++
 tb/tb_memory_mutator_ida.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/memory_mutator_ida.sv
// Store-path memory formatter: lane-aligns store data, runs a valid/ack bus write, reports done/errors.
// Optional MEM_SPLIT_STORE_EN: misaligned half/word stores become two bus writes instead of an error.
module memory_mutator_ida #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        access_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wrdata,
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ack,
    output logic              done,
    output logic              misaligned_flag,
    output logic              misaccess_flag
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_WRITE2 = 2'd2, S_ERR = 2'd3} state_t;

    state_t            state_q, state_d;
    logic              accept, illegal, misal, to_err, split_w;
    logic [1:0]        off;
    logic [3:0]        mask, lo_be;
    logic [31:0]       dm, lo_wd;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic              acc_q, done_q, mis_fl_q, acc_fl_q;
    logic              done_d, mis_fl_d, acc_fl_d;

    assign accept  = req_valid && req_ready;
    assign off     = req_addr[1:0];
    assign illegal = (access_size == 2'b00);

    // Size decode: lane mask before shifting, data masked to the access width.
    always_comb begin
        mask  = 4'b0000;
        dm    = '0;
        misal = 1'b0;
        case (access_size)
            2'b01: begin mask = 4'b0001; dm = {24'b0, req_data[7:0]}; end
            2'b10: begin mask = 4'b0011; dm = {16'b0, req_data[15:0]}; misal = (off == 2'd3); end
            2'b11: begin mask = 4'b1111; dm = req_data; misal = (off != 2'd0); end
            default: ;
        endcase
    end

`ifdef MEM_SPLIT_STORE_EN
    logic [7:0]  be_w;
    logic [63:0] wd_w;
    logic [3:0]  hi_be_q;
    logic [31:0] hi_wd_q;
    logic        split_q;

    // Shift into an 8-lane window: upper half is the second (addr+4) write.
    assign be_w    = {4'b0000, mask} << off;
    assign wd_w    = {32'b0, dm} << {off, 3'b000};
    assign lo_be   = be_w[3:0];
    assign lo_wd   = (access_size == 2'b01) ? {4{req_data[7:0]}} : wd_w[31:0];
    assign to_err  = illegal;
    assign split_w = split_q;
`else
    logic mis_q;

    assign lo_be   = mask << off;
    assign lo_wd   = (access_size == 2'b01) ? {4{req_data[7:0]}} : (dm << {off, 3'b000});
    assign to_err  = illegal || misal;
    assign split_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = to_err ? S_ERR : S_WRITE;
            S_WRITE:  if (mem_ack) state_d = split_w ? S_WRITE2 : S_IDLE;
            S_WRITE2: if (mem_ack) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        mem_we    = (state_q == S_WRITE) || (state_q == S_WRITE2);
        done_d    = (state_q == S_ERR) ||
                    (mem_ack && (((state_q == S_WRITE) && !split_w) || (state_q == S_WRITE2)));
        acc_fl_d  = (state_q == S_ERR) && acc_q;
`ifdef MEM_SPLIT_STORE_EN
        mis_fl_d  = 1'b0;
`else
        mis_fl_d  = (state_q == S_ERR) && mis_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            acc_q    <= 1'b0;
            done_q   <= 1'b0;
            mis_fl_q <= 1'b0;
            acc_fl_q <= 1'b0;
`ifdef MEM_SPLIT_STORE_EN
            hi_be_q  <= '0;
            hi_wd_q  <= '0;
            split_q  <= 1'b0;
`else
            mis_q    <= 1'b0;
`endif
        end else begin
            done_q   <= done_d;
            mis_fl_q <= mis_fl_d;
            acc_fl_q <= acc_fl_d;
            if (accept) begin
                addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                be_q   <= lo_be;
                wd_q   <= lo_wd;
                acc_q  <= illegal;
`ifdef MEM_SPLIT_STORE_EN
                hi_be_q <= be_w[7:4];
                hi_wd_q <= wd_w[63:32];
                split_q <= misal && !illegal;
            end else if ((state_q == S_WRITE) && mem_ack && split_q) begin
                addr_q <= addr_q + ADDR_W'(4);
                be_q   <= hi_be_q;
                wd_q   <= hi_wd_q;
`else
                mis_q  <= misal && !illegal;
`endif
            end
        end
    end

    assign mem_addr        = addr_q;
    assign mem_byte_en     = be_q;
    assign mem_wrdata      = wd_q;
    assign done            = done_q;
    assign misaligned_flag = mis_fl_q;
    assign misaccess_flag  = acc_fl_q;
endmodule

// File: tb/tb_memory_mutator_ida.sv
// Randomized bench for memory_mutator_ida against a byte-lane reference model.
module tb_memory_mutator_ida;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  access_size;
    logic        mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wrdata;
    logic [3:0]  mem_byte_en;
    logic        done, misaligned_flag, misaccess_flag;

    int total = 0;
    int bad   = 0;

    memory_mutator_ida #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .access_size(access_size),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
        .mem_byte_en(mem_byte_en), .mem_ack(mem_ack),
        .done(done), .misaligned_flag(misaligned_flag), .misaccess_flag(misaccess_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: place each data byte on lane off+i; lanes 4..7 spill into the second word.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         output int kind, output int nw,
                         output logic [31:0] a1, output logic [3:0] b1, output logic [31:0] w1,
                         output logic [31:0] a2, output logic [3:0] b2, output logic [31:0] w2);
        int nb, o;
        nb = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
        o  = int'(a[1:0]);
        a1 = {a[31:2], 2'b00};
        a2 = a1 + 32'd4;
        b1 = '0; b2 = '0; w1 = '0; w2 = '0;
        kind = 0; nw = 1;
        if (sz == 2'd0) begin
            kind = 2;
        end else if (o + nb > 4) begin
`ifdef MEM_SPLIT_STORE_EN
            nw = 2;
`else
            kind = 1;
`endif
        end
        if (sz == 2'd1) begin
            b1[o] = 1'b1;
            w1 = {4{d[7:0]}};
        end else begin
            for (int i = 0; i < nb; i++) begin
                int ln;
                ln = o + i;
                if (ln < 4) begin b1[ln] = 1'b1; w1[8*ln +: 8] = d[8*i +: 8]; end
                else begin b2[ln-4] = 1'b1; w2[8*(ln-4) +: 8] = d[8*i +: 8]; end
            end
        end
    endtask

    // Entered at a negedge where a write beat should be on the bus.
    task automatic bus_beat(input logic [31:0] ea, input logic [3:0] eb, input logic [31:0] ew,
                            input int dly);
        for (int c = 0; c <= dly; c++) begin
            chk("we", mem_we, 1);
            chk("addr", mem_addr, ea);
            chk("be", {28'b0, mem_byte_en}, {28'b0, eb});
            chk("wrdata", mem_wrdata, ew);
            chk("done_busy", done, 0);
            chk("ready_busy", req_ready, 0);
            if (c == dly) mem_ack = 1'b1;
            @(posedge clk); @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    // Issues one request at a negedge with req_ready expected high; ends at the done negedge.
    task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input int dly);
        int kind, nw;
        logic [31:0] a1, w1, a2, w2;
        logic [3:0]  b1, b2;
        model(a, d, sz, kind, nw, a1, b1, w1, a2, b2, w2);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_data = d; access_size = sz;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; access_size = 2'($urandom);
        if (kind != 0) begin
            chk("err_we", mem_we, 0);
            chk("err_done_early", done, 0);
            chk("err_ready", req_ready, 0);
            @(posedge clk); @(negedge clk);
        end else begin
            bus_beat(a1, b1, w1, dly);
            if (nw == 2) bus_beat(a2, b2, w2, dly);
        end
        chk("done", done, 1);
        chk("misaligned", misaligned_flag, (kind == 1) ? 1 : 0);
        chk("misaccess", misaccess_flag, (kind == 2) ? 1 : 0);
        chk("ready_done", req_ready, 1);
        chk("we_done", mem_we, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; access_size = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {misaligned_flag, misaccess_flag}, 0);
        chk("rst_be", {28'b0, mem_byte_en}, 0);
        chk("rst_wd", mem_wrdata, 0);

        run(32'h0000_0103, 32'h0000_00A5, 2'b01, 0);
        run(32'h0000_0201, 32'h0000_1234, 2'b10, 3);
        run(32'h0000_0302, 32'h1122_3344, 2'b11, 0);
        run(32'h0000_0400, 32'h5566_7788, 2'b00, 0);
        run(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b11, 1);
        run(32'h0000_0503, 32'hDEAD_BEEF, 2'b10, 2);

        // Reset while a write waits for ack.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0600; req_data = 32'h0BAD_F00D; access_size = 2'b11;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_we_before", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_done", done, 0);
            chk("rstmid_ready", req_ready, 1);
            chk("rstmid_we_after", mem_we, 0);
        end

        // Random traffic, mostly back-to-back from the done cycle.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a[31:4] = '1;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            run(a, $urandom, 2'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
